placar_multi: RTL and testbench

//  Parametrised game scoreboard for Breakout: score, lives and high-score counters, game FSM,
//  and sequential double-dabble BCD conversion to active-low 7-segment digits with leading-zero

---
 rtl/placar_multi.sv | 227 ++++++++++++++++++++++
 tb/tb_placar_multi.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/placar_multi.sv
// Breakout scoreboard: score/lives/high-score counters, game FSM and
// sequential double-dabble conversion to active-low 7-segment digits.
//
// state | meaning
// IDLE  | waiting for start
// PLAY  | ball in play, events counted
// LOST  | ball lost, waiting for start release
// OVER  | game lost, waiting for start pulse to restart
// WIN   | win threshold reached, waiting for start pulse to restart

// One double-dabble engine: latches its source, shifts W times, then copies
// the segment image; any source change restarts it so partial results never show.
module placar_multi_bcd #(
  parameter int W       = 10,
  parameter int DIG     = 3,
  parameter int RST_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     src,
  output logic [7*DIG-1:0] seg
);
  localparam int BW = 4 * DIG;
  localparam int CW = $clog2(W + 1);

  function automatic logic [6:0] dig7(input logic [3:0] d);
    case (d)
      4'd0:    dig7 = 7'b1000000;
      4'd1:    dig7 = 7'b1111001;
      4'd2:    dig7 = 7'b0100100;
      4'd3:    dig7 = 7'b0110000;
      4'd4:    dig7 = 7'b0011001;
      4'd5:    dig7 = 7'b0010010;
      4'd6:    dig7 = 7'b0000010;
      4'd7:    dig7 = 7'b1111000;
      4'd8:    dig7 = 7'b0000000;
      4'd9:    dig7 = 7'b0010000;
      default: dig7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] b_in, input logic bit_in);
    logic [BW-1:0] b;
    b = b_in;
    for (int k = 0; k < DIG; k++)
      if (b[4*k +: 4] > 4'd4) b[4*k +: 4] = b[4*k +: 4] + 4'd3;
    return {b[BW-2:0], bit_in};
  endfunction

  // Leading zeros above digit 0 are blanked
  function automatic logic [7*DIG-1:0] to_seg(input logic [BW-1:0] b);
    logic [7*DIG-1:0] s;
    logic blank;
    s = '1;
    blank = 1'b1;
    for (int k = DIG - 1; k >= 0; k--) begin
      if (k == 0 || b[4*k +: 4] != 4'd0) blank = 1'b0;
      s[7*k +: 7] = blank ? 7'b1111111 : dig7(b[4*k +: 4]);
    end
    return s;
  endfunction

  function automatic logic [BW-1:0] bin2bcd(input logic [W-1:0] v);
    logic [BW-1:0] b;
    b = '0;
    for (int i = W - 1; i >= 0; i--) b = dd_step(b, v[i]);
    return b;
  endfunction

  localparam logic [W-1:0]     SRC_RST = W'(RST_VAL);
  localparam logic [7*DIG-1:0] SEG_RST = to_seg(bin2bcd(SRC_RST));

  logic [W-1:0]  src_q;
  logic [W-1:0]  sh;
  logic [BW-1:0] bcd;
  logic [CW-1:0] cnt;
  logic          busy;

  // Restart on source change, otherwise shift until the down-counter expires, then publish
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src_q <= SRC_RST;
      sh    <= '0;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      seg   <= SEG_RST;
    end else if (src != src_q) begin
      src_q <= src;
      sh    <= src;
      bcd   <= '0;
      cnt   <= CW'(W);
      busy  <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        bcd <= dd_step(bcd, sh[W-1]);
        sh  <= {sh[W-2:0], 1'b0};
        cnt <= cnt - CW'(1);
      end else begin
        seg  <= to_seg(bcd);
        busy <= 1'b0;
      end
    end
  end
endmodule

module placar_multi #(
  parameter int SCORE_W    = 10,
  parameter int SCORE_DIG  = 3,
  parameter int LIVES_W    = 4,
  parameter int INIT_LIVES = 10,
  parameter int WIN_SCORE  = 10,
  parameter int PTS_HIT    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   hit_block,
  input  logic                   endgame_ball,
  input  logic                   endgame_block,
  input  logic                   start,
  input  logic                   show_hi,
  output logic [7*SCORE_DIG-1:0] score_seg,
  output logic [13:0]            lives_seg,
  output logic [2:0]             state_o,
  output logic                   game_over,
  output logic                   game_won
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    LOST = 3'd2,
    OVER = 3'd3,
    WIN  = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W:0]   PTS        = (SCORE_W + 1)'(PTS_HIT);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);

  state_t             state, state_n;
  logic [SCORE_W-1:0] score, score_n, hi, hi_n;
  logic [LIVES_W-1:0] lives, lives_n;
  logic [SCORE_W:0]   score_sum;
  logic               hit_q, ball_q, blk_q, start_q;
  logic               hit_p, ball_p, blk_p, start_p;

  // History regs reset high so a level already present at reset release is not an edge
  assign hit_p   = hit_block & ~hit_q;
  assign ball_p  = endgame_ball & ~ball_q;
  assign blk_p   = endgame_block & ~blk_q;
  assign start_p = start & ~start_q;

  // State, counters and edge-detect history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      score   <= '0;
      hi      <= '0;
      lives   <= LIVES_INIT;
      hit_q   <= 1'b1;
      ball_q  <= 1'b1;
      blk_q   <= 1'b1;
      start_q <= 1'b1;
    end else begin
      state   <= state_n;
      score   <= score_n;
      hi      <= hi_n;
      lives   <= lives_n;
      hit_q   <= hit_block;
      ball_q  <= endgame_ball;
      blk_q   <= endgame_block;
      start_q <= start;
    end
  end

  // Next state and counter updates; in PLAY ball beats block beats hit
  always_comb begin
    state_n   = state;
    score_n   = score;
    hi_n      = hi;
    lives_n   = lives;
    score_sum = {1'b0, score} + PTS;
    case (state)
      IDLE: if (start) state_n = PLAY;
      PLAY: begin
        if (ball_p) begin
          lives_n = lives - LIVES_W'(1);
          state_n = (lives_n == '0) ? OVER : LOST;
        end else if (blk_p) begin
          state_n = OVER;
        end else if (hit_p) begin
          score_n = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
          if (score_n >= WIN_VAL) state_n = WIN;
        end
      end
      LOST: if (!start) state_n = IDLE;
      OVER, WIN: begin
        if (score > hi) hi_n = score;
        if (start_p) begin
          score_n = '0;
          lives_n = LIVES_INIT;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign state_o   = state;
  assign game_over = (state == OVER);
  assign game_won  = (state == WIN);

  placar_multi_bcd #(.W(SCORE_W), .DIG(SCORE_DIG), .RST_VAL(0)) u_bcd_score (
    .clock (clock),
    .reset (reset),
    .src   (show_hi ? hi : score),
    .seg   (score_seg)
  );

  placar_multi_bcd #(.W(LIVES_W), .DIG(2), .RST_VAL(INIT_LIVES)) u_bcd_lives (
    .clock (clock),
    .reset (reset),
    .src   (lives),
    .seg   (lives_seg)
  );
endmodule

// File: tb/tb_placar_multi.sv
// Randomized scoreboard bench for placar_multi against a behavioural game model.
module tb_placar_multi;
  localparam int SCORE_W    = 10;
  localparam int SCORE_DIG  = 3;
  localparam int LIVES_W    = 4;
  localparam int INIT_LIVES = 10;
  localparam int WIN_SCORE  = 10;
  localparam int PTS_HIT    = 1;
  localparam int SMAX       = (1 << SCORE_W) - 1;
  localparam int SLAT       = SCORE_W + 2;
  localparam int LLAT       = LIVES_W + 2;

  logic clock, reset, hit_block, endgame_ball, endgame_block, start, show_hi;
  logic [7*SCORE_DIG-1:0] score_seg;
  logic [13:0] lives_seg;
  logic [2:0]  state_o;
  logic        game_over, game_won;

  placar_multi #(
    .SCORE_W(SCORE_W), .SCORE_DIG(SCORE_DIG), .LIVES_W(LIVES_W),
    .INIT_LIVES(INIT_LIVES), .WIN_SCORE(WIN_SCORE), .PTS_HIT(PTS_HIT)
  ) dut (
    .clock(clock), .reset(reset), .hit_block(hit_block), .endgame_ball(endgame_ball),
    .endgame_block(endgame_block), .start(start), .show_hi(show_hi),
    .score_seg(score_seg), .lives_seg(lives_seg), .state_o(state_o),
    .game_over(game_over), .game_won(game_won)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int cyc;
    int st;
    int sseg;
    int lseg;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clock) cyc++;

  // Model: states 0 idle, 1 play, 2 lost, 3 over, 4 win
  int m_st, m_score, m_hi, m_lives, d_score, d_lives;
  bit p_hit, p_ball, p_blk, p_start;
  int hs[$];
  int hl[$];

  function automatic int seg_of(int v, int nd);
    logic [6:0] t [10];
    int r, p;
    logic [6:0] d;
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    r = 0;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      if (k > 0 && v < p) d = 7'h7f;
      else d = t[(v / p) % 10];
      r = r | (int'(d) << (7 * k));
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_score = 0; m_hi = 0; m_lives = INIT_LIVES;
    p_hit = 1; p_ball = 1; p_blk = 1; p_start = 1;
    hs.delete(); hl.delete();
    for (int i = 0; i < SLAT; i++) hs.push_back(0);
    for (int i = 0; i < LLAT; i++) hl.push_back(INIT_LIVES);
    d_score = 0; d_lives = INIT_LIVES;
  endtask

  // A displayed value appears once its source has been stable for the whole conversion window
  task automatic m_display();
    bit same;
    hs.push_back(show_hi ? m_hi : m_score);
    if (hs.size() > SLAT) void'(hs.pop_front());
    same = 1;
    foreach (hs[i]) if (hs[i] != hs[0]) same = 0;
    if (same) d_score = hs[0];
    hl.push_back(m_lives);
    if (hl.size() > LLAT) void'(hl.pop_front());
    same = 1;
    foreach (hl[i]) if (hl[i] != hl[0]) same = 0;
    if (same) d_lives = hl[0];
  endtask

  task automatic m_step();
    bit hp, bp, kp, sp;
    hp = hit_block && !p_hit;
    bp = endgame_ball && !p_ball;
    kp = endgame_block && !p_blk;
    sp = start && !p_start;
    p_hit = hit_block; p_ball = endgame_ball; p_blk = endgame_block; p_start = start;
    case (m_st)
      0: if (start) m_st = 1;
      1: begin
        if (bp) begin
          m_lives = m_lives - 1;
          m_st = (m_lives == 0) ? 3 : 2;
        end else if (kp) begin
          m_st = 3;
        end else if (hp) begin
          m_score = m_score + PTS_HIT;
          if (m_score > SMAX) m_score = SMAX;
          if (m_score >= WIN_SCORE) m_st = 4;
        end
      end
      2: if (!start) m_st = 0;
      default: begin
        if (m_score > m_hi) m_hi = m_score;
        if (sp) begin
          m_score = 0;
          m_lives = INIT_LIVES;
          m_st = 0;
        end
      end
    endcase
  endtask

  task automatic push_exp();
    exp_t e;
    e.cyc  = cyc + 1;
    e.st   = m_st;
    e.sseg = seg_of(d_score, SCORE_DIG);
    e.lseg = seg_of(d_lives, 2);
    q.push_back(e);
  endtask

  task automatic chk_reset_now();
    chk("rst_state", int'(state_o), 0);
    chk("rst_score_seg", int'(score_seg), seg_of(0, SCORE_DIG));
    chk("rst_lives_seg", int'(lives_seg), seg_of(INIT_LIVES, 2));
    chk("rst_flags", int'({game_over, game_won}), 0);
  endtask

  // Monitor: compare every registered output against the expectation for this edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("state_o", int'(state_o), e.st);
        chk("game_over", int'(game_over), int'(e.st == 3));
        chk("game_won", int'(game_won), int'(e.st == 4));
        chk("score_seg", int'(score_seg), e.sseg);
        chk("lives_seg", int'(lives_seg), e.lseg);
      end
    end
  end

  // Stimulus: random levels on event inputs, occasional asynchronous reset
  initial begin
    int rst_hold;
    reset = 1'b0;
    hit_block = 1'b0; endgame_ball = 1'b0; endgame_block = 1'b0;
    start = 1'b0; show_hi = 1'b0;
    m_reset();
    repeat (2) @(posedge clock);
    #2;
    chk_reset_now();
    rst_hold = 1;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clock);
      #2;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        rst_hold = 3;
        q.delete();
        m_reset();
        #1;
        chk_reset_now();
      end
      hit_block     = ($urandom_range(0, 99) < 45);
      endgame_ball  = ($urandom_range(0, 99) < 3);
      endgame_block = ($urandom_range(0, 99) < 1);
      start         = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 8) show_hi = ~show_hi;
      if (!reset) m_reset();
      else begin
        m_display();
        m_step();
      end
      push_exp();
    end
    repeat (3) @(posedge clock);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
